// File: rtl/fetch_stage.sv
// fetch_stage: sequential PC generation, credit-limited imem requests, in-order response
// buffering and decode-side field split with redirect flush and stale-response dropping.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        f7,
  output logic [24:0] immSample
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] r_pc, r_hold_pc;
  logic [CW-1:0] r_out, r_stale, r_cnt;
  logic [AW-1:0] r_wp, r_rp, r_qwp, r_qrp;
  logic [31:0] r_qpc [FIFO_DEPTH];
  logic [31:0] r_fpc [FIFO_DEPTH];
  logic [31:0] r_fdat [FIFO_DEPTH];
  logic w_empty, w_pop, w_acc, w_rsp, w_push;
  logic [CW:0] w_used;
  logic [CW-1:0] w_out_nx;
  logic [31:0] w_instr;
  // A head popped this cycle frees its slot, so credit counts it back to keep one instruction per cycle.
  always_comb begin
    w_empty = r_cnt == '0;
    w_pop = !w_empty && !stall;
    w_used = {1'b0, r_out} + {1'b0, r_cnt} - (CW+1)'(w_pop);
    imem_req_valid = !rst && !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
    imem_req_addr = r_pc;
    w_acc = imem_req_valid && imem_req_ready;
    w_rsp = imem_rsp_valid && r_out != '0;
    w_push = w_rsp && r_stale == '0 && !redirect_valid;
    w_out_nx = r_out + CW'(w_acc) - CW'(w_rsp);
    dec_valid = !w_empty;
    dec_pc = w_empty ? r_hold_pc : r_fpc[r_rp];
    w_instr = w_empty ? NOP : r_fdat[r_rp];
    opcode = w_instr[6:0];
    func3 = w_instr[14:12];
    f7 = w_instr[30];
    immSample = w_instr[31:7];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_hold_pc <= RESET_PC;
      r_out <= '0;
      r_stale <= '0;
      r_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_qwp <= '0;
      r_qrp <= '0;
    end else begin
      r_out <= w_out_nx;
      if (w_acc) r_qwp <= r_qwp + AW'(1);
      if (w_rsp) r_qrp <= r_qrp + AW'(1);
      if (!w_empty) r_hold_pc <= r_fpc[r_rp];
      if (redirect_valid) begin
        r_pc <= redirect_pc & ~32'h3;
        r_stale <= w_out_nx;
        r_cnt <= '0;
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_acc) r_pc <= r_pc + 32'd4;
        if (w_rsp && r_stale != '0) r_stale <= r_stale - CW'(1);
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  // Storage needs no reset: pointers and counts qualify every read.
  always_ff @(posedge clk) begin
    if (w_acc) r_qpc[r_qwp] <= r_pc;
    if (w_push) begin
      r_fpc[r_wp] <= r_qpc[r_qrp];
      r_fdat[r_wp] <= imem_rsp_data;
    end
  end
  a_credit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, r_out} + {1'b0, r_cnt}) <= (CW+1)'(FIFO_DEPTH));
  a_stale: assert property (@(posedge clk) disable iff (rst) r_stale <= r_out);
endmodule
